dmem_resp: RTL and testbench



---
 rtl/dmem_resp_if.sv | 23 ++
 rtl/dmem_resp.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_resp.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// Core-to-data-memory bus: one access per cycle, loads answered in the same cycle.
interface dmem_resp_if #(
    parameter int XLEN = 32
);
    logic            adr_v_i;
    logic [XLEN-1:0] adr_i;
    logic            is_store_i;
    logic [XLEN-1:0] store_data_i;
    logic [2:0]      access_size_i;
    logic [XLEN-1:0] load_data_o;
    logic            misaligned_o;
    logic            bus_err_o;

    modport master (
        output adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
        input  load_data_o, misaligned_o, bus_err_o
    );

    modport slave (
        input  adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
        output load_data_o, misaligned_o, bus_err_o
    );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: byte-lane RAM, 64-bit cycle counter over MMIO and a TOHOST halt register.
// Define DMEM_IPORT_EN to add a read-only instruction fetch port onto the same RAM.
module dmem_resp #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RAM_BASE   = 32'h0000_0000,
    parameter int              RAM_WORDS  = 4096,
    parameter logic [XLEN-1:0] TOHOST_ADR = 32'h8000_0000,
    parameter logic [XLEN-1:0] CYCLE_ADR  = 32'h8000_0010
) (
    input  logic            clk,
    input  logic            reset_n,
    dmem_resp_if.slave      bus,
    output logic            halt_o,
    output logic [XLEN-1:0] tohost_o
`ifdef DMEM_IPORT_EN
    ,
    input  logic [XLEN-1:0] icache_adr_i,
    output logic [31:0]     icache_instr_o
`endif
);

    localparam int              IDX_W     = $clog2(RAM_WORDS);
    localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(RAM_WORDS * 4);
    localparam logic [XLEN-1:0] CYCLE_HI  = CYCLE_ADR + XLEN'(4);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              halt_r;
    logic [XLEN-1:0]   tohost_r;
    logic [63:0]       cycle_cnt_r;
    logic [XLEN-1:0]   ram_r [RAM_WORDS];

    logic [XLEN-1:0]   ram_off_s;
    logic [IDX_W-1:0]  ram_idx_s;
    logic              ram_hit_s;
    logic              tohost_hit_s;
    logic              cyc_lo_hit_s;
    logic              cyc_hi_hit_s;
    logic              any_hit_s;
    logic              mis_s;
    logic              acc_ok_s;
    logic              commit_s;
    logic              tohost_we_s;
    logic [3:0]        be_s;
    logic [XLEN-1:0]   wdata_s;
    logic [XLEN-1:0]   rd_word_s;
    logic [XLEN-1:0]   shifted_s;
    logic [XLEN-1:0]   ld_data_s;

    // Replace only the enabled byte lanes of a stored word.
    function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0] old_word,
                                                    input logic [XLEN-1:0] new_word,
                                                    input logic [3:0]      be);
        logic [XLEN-1:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address decode; an address below RAM_BASE wraps to a large offset and misses.
    always_comb begin
        ram_off_s    = bus.adr_i - RAM_BASE;
        ram_hit_s    = (ram_off_s < RAM_BYTES);
        ram_idx_s    = ram_off_s[IDX_W+1:2];
        tohost_hit_s = (bus.adr_i == TOHOST_ADR);
        cyc_lo_hit_s = (bus.adr_i == CYCLE_ADR);
        cyc_hi_hit_s = (bus.adr_i == CYCLE_HI);
        any_hit_s    = ram_hit_s | tohost_hit_s | cyc_lo_hit_s | cyc_hi_hit_s;
    end

    // Size decode: alignment check plus lane enables and lane-replicated write data.
    always_comb begin
        mis_s   = 1'b0;
        be_s    = 4'b0000;
        wdata_s = '0;
        case (bus.access_size_i)
            3'b001: begin
                be_s    = 4'b0001 << bus.adr_i[1:0];
                wdata_s = {4{bus.store_data_i[7:0]}};
            end
            3'b010: begin
                mis_s   = bus.adr_i[0];
                be_s    = 4'b0011 << {bus.adr_i[1], 1'b0};
                wdata_s = {2{bus.store_data_i[15:0]}};
            end
            3'b100: begin
                mis_s   = |bus.adr_i[1:0];
                be_s    = 4'b1111;
                wdata_s = bus.store_data_i;
            end
            default: begin
                mis_s = 1'b1;
            end
        endcase
    end

    assign acc_ok_s         = bus.adr_v_i & ~mis_s & any_hit_s;
    assign commit_s         = acc_ok_s & bus.is_store_i;
    assign tohost_we_s      = commit_s & tohost_hit_s & (state_r == ST_RUN);
    assign bus.misaligned_o = bus.adr_v_i & mis_s;
    assign bus.bus_err_o    = bus.adr_v_i & ~any_hit_s;

    // Zero-latency load path: pick the target word, align it down, zero-fill above.
    always_comb begin
        rd_word_s = '0;
        if (ram_hit_s) begin
            rd_word_s = ram_r[ram_idx_s];
        end else if (tohost_hit_s) begin
            rd_word_s = tohost_r;
        end else if (cyc_lo_hit_s) begin
            rd_word_s = cycle_cnt_r[31:0];
        end else if (cyc_hi_hit_s) begin
            rd_word_s = cycle_cnt_r[63:32];
        end else begin
            rd_word_s = '0;
        end
        shifted_s = rd_word_s >> {bus.adr_i[1:0], 3'b000};
        ld_data_s = '0;
        if (acc_ok_s) begin
            case (bus.access_size_i)
                3'b001:  ld_data_s = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
                3'b010:  ld_data_s = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
                default: ld_data_s = shifted_s;
            endcase
        end else begin
            ld_data_s = '0;
        end
        bus.load_data_o = ld_data_s;
    end

    // RAM is not reset; a store racing with an active reset is dropped.
    always_ff @(posedge clk) begin
        if (commit_s && ram_hit_s && reset_n) begin
            ram_r[ram_idx_s] <= merge_lanes(ram_r[ram_idx_s], wdata_s, be_s);
        end
    end

    // Halt sequencing: the first committed TOHOST store stops the test for good.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (commit_s && tohost_hit_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // State, TOHOST capture and the cycle counter, which freezes once halted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            halt_r      <= 1'b0;
            tohost_r    <= '0;
            cycle_cnt_r <= 64'd0;
        end else begin
            state_r <= state_nxt_s;
            halt_r  <= (state_nxt_s == ST_HALTED);
            if (tohost_we_s) begin
                tohost_r <= bus.store_data_i;
            end
            if (state_r == ST_RUN) begin
                cycle_cnt_r <= cycle_cnt_r + 64'd1;
            end
        end
    end

    assign halt_o   = halt_r;
    assign tohost_o = tohost_r;

`ifdef DMEM_IPORT_EN
    logic [XLEN-1:0]  iram_off_s;
    logic [IDX_W-1:0] iram_idx_s;
    logic             ifetch_ok_s;

    // Fetch reads the array directly, so a same-cycle store is seen only next cycle.
    always_comb begin
        iram_off_s  = icache_adr_i - RAM_BASE;
        iram_idx_s  = iram_off_s[IDX_W+1:2];
        ifetch_ok_s = (iram_off_s < RAM_BYTES) && (icache_adr_i[1:0] == 2'b00);
        if (ifetch_ok_s) begin
            icache_instr_o = ram_r[iram_idx_s];
        end else begin
            icache_instr_o = 32'h0000_0013;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: RAM lanes, decode errors, cycle counter and TOHOST halt.
module tb_dmem_resp;

    localparam logic [31:0] TOHOST_ADR = 32'h8000_0000;
    localparam logic [31:0] CYCLE_ADR  = 32'h8000_0010;
    localparam logic [2:0]  SZ_B       = 3'b001;
    localparam logic [2:0]  SZ_H       = 3'b010;
    localparam logic [2:0]  SZ_W       = 3'b100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        halt_s;
    logic [31:0] tohost_s;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_resp_if #(.XLEN(32)) bus ();

`ifdef DMEM_IPORT_EN
    logic [31:0] icache_adr_s = 32'h0;
    logic [31:0] icache_instr_s;
`endif

    dmem_resp dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .halt_o   (halt_s),
        .tohost_o (tohost_s)
`ifdef DMEM_IPORT_EN
        ,
        .icache_adr_i   (icache_adr_s),
        .icache_instr_o (icache_instr_s)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] adr, input logic [31:0] data,
                         input logic [2:0] size);
        bus.adr_v_i       = 1'b1;
        bus.is_store_i    = st;
        bus.adr_i         = adr;
        bus.store_data_i  = data;
        bus.access_size_i = size;
        #1;
    endtask

    task automatic go_idle();
        bus.adr_v_i       = 1'b0;
        bus.is_store_i    = 1'b0;
        bus.adr_i         = 32'h0;
        bus.store_data_i  = 32'h0;
        bus.access_size_i = SZ_W;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] adr, input logic [2:0] size,
                            input logic [31:0] exp);
        drive(1'b0, adr, 32'h0, size);
        check_eq(tag, {32'h0, bus.load_data_o}, {32'h0, exp});
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data, input logic [2:0] size);
        drive(1'b1, adr, data, size);
        tick();
        go_idle();
    endtask

    initial begin
        go_idle();
        repeat (2) @(negedge clk);
        check_eq("rst_halt", {63'h0, halt_s}, 64'h0);
        check_eq("rst_tohost", {32'h0, tohost_s}, 64'h0);
        bus.adr_i = 32'h0000_0100;
        #1;
        check_eq("idle_load_zero", {32'h0, bus.load_data_o}, 64'h0);

        // Counter counts one per posedge after release.
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        load_chk("cycle_lo_10", CYCLE_ADR, SZ_W, 32'd10);
        load_chk("cycle_hi_10", CYCLE_ADR + 32'd4, SZ_W, 32'd0);
        go_idle();

        // Word store and lane loads.
        tick();
        drive(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, SZ_W);
        check_eq("st_w_mis", {63'h0, bus.misaligned_o}, 64'h0);
        check_eq("st_w_err", {63'h0, bus.bus_err_o}, 64'h0);
        tick();
        go_idle();
        load_chk("ld_b0", 32'h0000_0100, SZ_B, 32'h0000_00EF);
        load_chk("ld_b1", 32'h0000_0101, SZ_B, 32'h0000_00BE);
        load_chk("ld_b2", 32'h0000_0102, SZ_B, 32'h0000_00AD);
        tick();
        load_chk("ld_b3", 32'h0000_0103, SZ_B, 32'h0000_00DE);
        load_chk("ld_w", 32'h0000_0100, SZ_W, 32'hDEAD_BEEF);
        tick();

        // Partial-lane merges.
        store(32'h0000_0101, 32'hFFFF_FF55, SZ_B);
        load_chk("merge_b", 32'h0000_0100, SZ_W, 32'hDEAD_55EF);
        tick();
        store(32'h0000_0102, 32'hABCD_1234, SZ_H);
        load_chk("merge_h", 32'h0000_0100, SZ_W, 32'h1234_55EF);
        load_chk("ld_h_hi", 32'h0000_0102, SZ_H, 32'h0000_1234);
        tick();

        // Misalignment, bad sizes and decode errors.
        load_chk("mis_h_data", 32'h0000_0101, SZ_H, 32'h0);
        check_eq("mis_h_flag", {63'h0, bus.misaligned_o}, 64'h1);
        drive(1'b1, 32'h0000_0102, 32'hFFFF_FFFF, SZ_W);
        check_eq("mis_w_flag", {63'h0, bus.misaligned_o}, 64'h1);
        tick();
        go_idle();
        load_chk("mis_w_nowrite", 32'h0000_0100, SZ_W, 32'h1234_55EF);
        load_chk("bad_size_data", 32'h0000_0100, 3'b011, 32'h0);
        check_eq("bad_size_flag", {63'h0, bus.misaligned_o}, 64'h1);
        tick();
        load_chk("berr_data", 32'h4000_0000, SZ_W, 32'h0);
        check_eq("berr_flag", {63'h0, bus.bus_err_o}, 64'h1);
        go_idle();
        tick();

        // Top word of RAM is in range; the next word is not.
        store(32'h0000_3FFC, 32'hA5A5_5A5A, SZ_W);
        load_chk("ram_top", 32'h0000_3FFC, SZ_W, 32'hA5A5_5A5A);
        check_eq("ram_top_err", {63'h0, bus.bus_err_o}, 64'h0);
        load_chk("ram_end_data", 32'h0000_4000, SZ_W, 32'h0);
        check_eq("ram_end_err", {63'h0, bus.bus_err_o}, 64'h1);
        tick();

        // Stores to the counter are silently ignored.
        drive(1'b1, CYCLE_ADR, 32'h0000_0005, SZ_W);
        check_eq("cyc_st_err", {63'h0, bus.bus_err_o}, 64'h0);
        check_eq("cyc_st_mis", {63'h0, bus.misaligned_o}, 64'h0);
        tick();
        go_idle();

        // Counter wraps 2^64-1 -> 0.
        force dut.cycle_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        load_chk("cyc_forced_lo", CYCLE_ADR, SZ_W, 32'hFFFF_FFFF);
        release dut.cycle_cnt_r;
        go_idle();
        tick();
        load_chk("cyc_wrap_lo", CYCLE_ADR, SZ_W, 32'h0);
        load_chk("cyc_wrap_hi", CYCLE_ADR + 32'd4, SZ_W, 32'h0);
        go_idle();

`ifdef DMEM_IPORT_EN
        tick();
        store(32'h0000_0200, 32'h0, SZ_W);
        icache_adr_s = 32'h0000_0200;
        drive(1'b1, 32'h0000_0200, 32'h00A0_0093, SZ_W);
        check_eq("if_same_cycle_old", {32'h0, icache_instr_s}, 64'h0);
        tick();
        go_idle();
        check_eq("if_fetch", {32'h0, icache_instr_s}, {32'h0, 32'h00A0_0093});
        icache_adr_s = 32'h0000_0202;
        #1;
        check_eq("if_mis_nop", {32'h0, icache_instr_s}, 64'h13);
        icache_adr_s = 32'h0000_4000;
        #1;
        check_eq("if_oor_nop", {32'h0, icache_instr_s}, 64'h13);
`endif

        // Fresh reset, then TOHOST store after three counted cycles.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        drive(1'b1, TOHOST_ADR, 32'h0000_0001, SZ_W);
        check_eq("pre_halt", {63'h0, halt_s}, 64'h0);
        tick();
        go_idle();
        check_eq("halt_set", {63'h0, halt_s}, 64'h1);
        check_eq("tohost_set", {32'h0, tohost_s}, 64'h1);
        load_chk("cyc_at_halt", CYCLE_ADR, SZ_W, 32'd4);
        load_chk("tohost_read", TOHOST_ADR, SZ_W, 32'h1);
        go_idle();
        tick();
        store(TOHOST_ADR, 32'h0000_0002, SZ_W);
        check_eq("tohost_frozen", {32'h0, tohost_s}, 64'h1);
        check_eq("halt_sticky", {63'h0, halt_s}, 64'h1);
        tick();
        store(32'h0000_0104, 32'hCAFE_F00D, SZ_W);
        load_chk("halted_ram", 32'h0000_0104, SZ_W, 32'hCAFE_F00D);
        go_idle();
        repeat (3) tick();
        load_chk("cyc_frozen_lo", CYCLE_ADR, SZ_W, 32'd4);
        load_chk("cyc_frozen_hi", CYCLE_ADR + 32'd4, SZ_W, 32'd0);

        // Reset mid-store: registers clear at once, the store is dropped.
        tick();
        drive(1'b1, 32'h0000_0104, 32'h1111_1111, SZ_W);
        reset_n = 1'b0;
        #1;
        check_eq("async_halt", {63'h0, halt_s}, 64'h0);
        check_eq("async_tohost", {32'h0, tohost_s}, 64'h0);
        tick();
        go_idle();
        load_chk("rst_store_drop", 32'h0000_0104, SZ_W, 32'hCAFE_F00D);
        load_chk("rst_cyc_zero", CYCLE_ADR, SZ_W, 32'd0);
        go_idle();
        @(negedge clk);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
